ibuf_load_ctrl: RTL and testbench

//  Sequences tile loads into the ARRAY_SIZE input-buffer columns that feed the systolic array.
//  Per tile: reads ARRAY_SIZE consecutive words from the input SRAM and writes each into its

---
 rtl/ibuf_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ibuf_load_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuf_load_ctrl.sv
// rtl/ibuf_load_ctrl.sv - tile load sequencer for the systolic-array input-buffer columns
//
// Purpose:
//   Per tile, reads ARRAY_SIZE consecutive words from the input SRAM and writes
//   each one into its own column buffer with a one-hot write enable. Once all
//   columns are written it raises tile_valid and holds it until tile_ack, then
//   continues with the next tile at the next SRAM address, for num_tiles tiles.
//   The number of zero-valued words of the current tile is reported on zero_cnt.
//
// Ports:
//   clk          rising-edge clock
//   nRST         asynchronous active-low reset
//   start        one-cycle job start, sampled only while idle
//   base_addr    first SRAM word address of the job (captured on start)
//   num_tiles    number of tiles in the job (captured on start)
//   busy         high in every state except idle
//   done         one-cycle pulse at job completion
//   mem_rd_en    SRAM read strobe (read data returns one cycle later)
//   mem_addr     SRAM word address
//   mem_rd_data  SRAM read data
//   ibuf_wr_en   one-hot column-buffer write enable
//   ibuf_data    column-buffer write data (pass-through of mem_rd_data)
//   tile_valid   all columns of the current tile are written
//   tile_ack     array has consumed the tile (honoured only while tile_valid)
//   zero_cnt     zero words seen in the current tile

module ibuf_load_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int TILE_W     = 8,
  localparam int ZC_W      = $clog2(ARRAY_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [TILE_W-1:0]     num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic [ARRAY_SIZE-1:0] ibuf_wr_en,
  output logic [DATA_W-1:0]     ibuf_data,
  output logic                  tile_valid,
  input  logic                  tile_ack,
  output logic [ZC_W-1:0]       zero_cnt
);

  localparam int K_W = $clog2(ARRAY_SIZE);
  localparam logic [K_W-1:0]        K_LAST = K_W'(ARRAY_SIZE - 1);
  localparam logic [ARRAY_SIZE-1:0] COL0   = ARRAY_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_VALID,
    S_DONE
  } state_t;

  state_t            state;
  logic [K_W-1:0]    word_idx;   // column index of the read being issued
  logic [TILE_W-1:0] tile_cnt;   // tiles still to be delivered, including the current one

  // The SRAM returns data exactly one cycle after the strobe, which is the
  // same cycle the matching column write enable is presented.
  assign ibuf_data = mem_rd_data;

  // mem_addr is itself the running address register: it is loaded with
  // base_addr on start and advances once per issued read, so successive tiles
  // continue contiguously and wrap silently at 2^ADDR_W.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      tile_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      ibuf_wr_en <= '0;
      tile_valid <= 1'b0;
      zero_cnt   <= '0;
    end else begin
      ibuf_wr_en <= '0;
      done       <= 1'b0;

      // Count a zero word in the cycle its column write is presented. The
      // clear on tile entry below overrides this; no write is ever pending
      // on those transitions, so no count is lost.
      if ((|ibuf_wr_en) && (mem_rd_data == '0)) begin
        zero_cnt <= zero_cnt + ZC_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr <= base_addr;
            tile_cnt <= num_tiles;
            word_idx <= '0;
            busy     <= 1'b1;
            if (num_tiles != '0) begin
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              zero_cnt  <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          mem_addr   <= mem_addr + ADDR_W'(1);
          ibuf_wr_en <= COL0 << word_idx;
          if (word_idx == K_LAST) begin
            word_idx  <= '0;
            mem_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            word_idx <= word_idx + K_W'(1);
          end
        end

        // The last column's write is presented during this cycle.
        S_DRAIN: begin
          state      <= S_VALID;
          tile_valid <= 1'b1;
        end

        S_VALID: begin
          if (tile_ack) begin
            tile_valid <= 1'b0;
            tile_cnt   <= tile_cnt - TILE_W'(1);
            if (tile_cnt == TILE_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              zero_cnt  <= '0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          mem_rd_en  <= 1'b0;
          tile_valid <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the sequencer.
  assert property (@(posedge clk) disable iff (!nRST) $onehot0(ibuf_wr_en));
  assert property (@(posedge clk) disable iff (!nRST) mem_rd_en |-> (state == S_FETCH));
  assert property (@(posedge clk) disable iff (!nRST) tile_valid |-> (state == S_VALID));
  assert property (@(posedge clk) disable iff (!nRST) !(done && tile_valid));

endmodule

// File: tb/tb_ibuf_load_ctrl.sv
// tb/tb_ibuf_load_ctrl.sv - scoreboard testbench for ibuf_load_ctrl

module tb_ibuf_load_ctrl;

  localparam int AS = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TW = 8;

  typedef struct packed {
    logic [AS-1:0] en;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          nRST;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [TW-1:0] num_tiles;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AS-1:0] ibuf_wr_en;
  logic [DW-1:0] ibuf_data;
  logic          tile_valid;
  logic          tile_ack;
  logic [2:0]    zero_cnt;

  ibuf_load_ctrl #(
    .ARRAY_SIZE(AS),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TILE_W    (TW)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
    .start      (start),
    .base_addr  (base_addr),
    .num_tiles  (num_tiles),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .ibuf_wr_en (ibuf_wr_en),
    .ibuf_data  (ibuf_data),
    .tile_valid (tile_valid),
    .tile_ack   (tile_ack),
    .zero_cnt   (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] exp_addr[$];
  wr_t           exp_wr[$];
  logic [2:0]    exp_zc[$];

  // SRAM model: word = address + 1, with up to two addresses forced to zero.
  bit            zero_en = 1'b0;
  logic [AW-1:0] za = '0;
  logic [AW-1:0] zb = '0;
  logic [DW-1:0] rd_q = '0;
  bit            ovr_en = 1'b0;
  logic [DW-1:0] ovr_data = '0;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    if (zero_en && (a == za || a == zb)) return '0;
    return {{(DW-AW){1'b0}}, a} + 32'd1;
  endfunction

  always @(posedge clk) if (mem_rd_en) rd_q <= word_at(mem_addr);
  assign mem_rd_data = ovr_en ? ovr_data : rd_q;

  // Scoreboard monitor, sampling on the falling edge.
  bit         tv_q = 1'b0;
  logic [2:0] zc_held = '0;
  always @(negedge clk) begin
    if (nRST) begin
      if (mem_rd_en) begin
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: mem_addr=%h, no read expected", mem_addr);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_addr.pop_front();
          if (mem_addr !== ea) begin
            n_bad++;
            $display("FAIL rd_addr: got %h want %h", mem_addr, ea);
          end
        end
      end
      if (ibuf_wr_en !== '0) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL wr_unexpected: wr_en=%b data=%h, no write expected", ibuf_wr_en, ibuf_data);
        end else begin
          wr_t ew;
          ew = exp_wr.pop_front();
          if (ibuf_wr_en !== ew.en || ibuf_data !== ew.data) begin
            n_bad++;
            $display("FAIL wr: got en=%b data=%h want en=%b data=%h", ibuf_wr_en, ibuf_data, ew.en, ew.data);
          end
        end
      end
      if (tile_valid && !tv_q) begin
        n_cmp++;
        if (exp_zc.size() == 0) begin
          n_bad++;
          $display("FAIL tile_unexpected: tile_valid with no tile expected");
        end else begin
          zc_held = exp_zc.pop_front();
          if (zero_cnt !== zc_held) begin
            n_bad++;
            $display("FAIL zero_cnt: got %0d want %0d", zero_cnt, zc_held);
          end
        end
      end else if (tile_valid && zero_cnt !== zc_held) begin
        n_cmp++;
        n_bad++;
        $display("FAIL zero_cnt_stable: got %0d want %0d", zero_cnt, zc_held);
      end
      n_cmp++;
      if (!$onehot0(ibuf_wr_en) || (done && tile_valid) || (mem_rd_en && tile_valid)
          || (tile_valid && ibuf_wr_en != '0) || (!busy && (mem_rd_en || tile_valid))) begin
        n_bad++;
        $display("FAIL invariant: wr_en=%b done=%b tv=%b rd=%b busy=%b want exclusive strobes",
                 ibuf_wr_en, done, tile_valid, mem_rd_en, busy);
      end
      tv_q = tile_valid;
    end else begin
      tv_q = 1'b0;
    end
  end

  task automatic push_job(input logic [AW-1:0] base, input int nt);
    logic [AW-1:0] a;
    logic [2:0]    zc;
    for (int t = 0; t < nt; t++) begin
      zc = '0;
      for (int w = 0; w < AS; w++) begin
        a = base + AW'(t * AS + w);
        exp_addr.push_back(a);
        exp_wr.push_back({AS'(1 << w), word_at(a)});
        if (word_at(a) == '0) zc++;
      end
      exp_zc.push_back(zc);
    end
  endtask

  // Runs one job and reports observed timing (cycle c = c-th falling edge after edge 0).
  task automatic run_job(input logic [AW-1:0] base, input int nt, input int dly_first,
                         input bit early_ack, input int mid_start,
                         output int t_rd, output int t_valid, output int t_done, output int t_idle,
                         output int n_rd, output int n_wr, output int n_done,
                         output int first_dwell, output int gap, output bit timeout);
    int c, dwell, tiles_seen, low_run;
    bit prev_tv;
    t_rd = -1; t_valid = -1; t_done = -1; t_idle = -1;
    n_rd = 0; n_wr = 0; n_done = 0; first_dwell = -1; gap = -1; timeout = 1'b0;
    push_job(base, nt);
    @(negedge clk);
    base_addr = base;
    num_tiles = TW'(nt);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; dwell = 0; tiles_seen = 0; low_run = 0; prev_tv = 1'b0;
    while (1) begin
      @(negedge clk);
      c++;
      if (mem_rd_en) begin
        n_rd++;
        if (t_rd < 0) t_rd = c;
      end
      if (ibuf_wr_en != '0) n_wr++;
      if (done) begin
        n_done++;
        t_done = c;
      end
      if (tile_valid) begin
        if (!prev_tv) begin
          if (t_valid < 0) t_valid = c;
          if (tiles_seen > 0) gap = low_run;
          dwell = 0;
        end
        dwell++;
      end else begin
        if (prev_tv) begin
          tiles_seen++;
          if (tiles_seen == 1) first_dwell = dwell;
          low_run = 0;
        end
        low_run++;
      end
      tile_ack = tile_valid && (dwell > ((tiles_seen == 0) ? dly_first : 0));
      if (early_ack && !tile_valid && tiles_seen == 0 && c <= AS + 1) tile_ack = 1'b1;
      start = (c == mid_start);
      if (c == mid_start) base_addr = base ^ 10'h155;
      prev_tv = tile_valid;
      if (!busy) begin
        t_idle = c;
        break;
      end
      if (c >= 5000) begin
        timeout = 1'b1;
        break;
      end
    end
    tile_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    ovr_en = 1'b1;
    ovr_data = 32'hA5A5_0F0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_rd_en, tile_valid, ibuf_wr_en, zero_cnt, mem_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b tv=%b wr=%b zc=%0d addr=%h want all 0",
               busy, done, mem_rd_en, tile_valid, ibuf_wr_en, zero_cnt, mem_addr);
    end
    n_cmp++;
    if (ibuf_data !== 32'hA5A5_0F0F) begin
      n_bad++;
      $display("FAIL reset_passthrough: ibuf_data=%h want a5a50f0f", ibuf_data);
    end
    ovr_en = 1'b0;
    nRST = 1'b1;
  endtask

  task automatic check_leftover(input string name);
    n_cmp++;
    if (exp_addr.size() != 0 || exp_wr.size() != 0 || exp_zc.size() != 0) begin
      n_bad++;
      $display("FAIL %s_leftover: reads=%0d writes=%0d tiles=%0d still expected, want 0",
               name, exp_addr.size(), exp_wr.size(), exp_zc.size());
    end
    exp_addr.delete(); exp_wr.delete(); exp_zc.delete();
  endtask

  task automatic test_single;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    zero_en = 1'b0;
    run_job(10'h010, 1, 0, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || t_rd != 1 || t_valid != 6 || t_done != 7 || t_idle != 8) begin
      n_bad++;
      $display("FAIL single_timing: to=%b rd=%0d valid=%0d done=%0d idle=%0d want 0/1/6/7/8",
               to, t_rd, t_valid, t_done, t_idle);
    end
    n_cmp++;
    if (n_rd != 4 || n_wr != 4 || n_done != 1 || dw != 1) begin
      n_bad++;
      $display("FAIL single_counts: rd=%0d wr=%0d done=%0d dwell=%0d want 4/4/1/1", n_rd, n_wr, n_done, dw);
    end
    check_leftover("single");
  endtask

  task automatic test_zero_tiles;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    run_job(10'h055, 0, 0, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || t_done != 1 || t_idle != 2 || n_done != 1) begin
      n_bad++;
      $display("FAIL zero_tiles_timing: to=%b done=%0d idle=%0d n_done=%0d want 0/1/2/1", to, t_done, t_idle, n_done);
    end
    n_cmp++;
    if (n_rd != 0 || n_wr != 0 || t_valid != -1) begin
      n_bad++;
      $display("FAIL zero_tiles_access: rd=%0d wr=%0d valid=%0d want 0/0/-1", n_rd, n_wr, t_valid);
    end
    check_leftover("zero_tiles");
  endtask

  task automatic test_zero_words;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    zero_en = 1'b1; za = 10'h101; zb = 10'h103;
    run_job(10'h100, 1, 2, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_wr != 4 || dw != 3 || n_done != 1) begin
      n_bad++;
      $display("FAIL zero_words: to=%b wr=%0d dwell=%0d done=%0d want 0/4/3/1", to, n_wr, dw, n_done);
    end
    zero_en = 1'b0;
    check_leftover("zero_words");
  endtask

  task automatic test_multi_tile;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    zero_en = 1'b1; za = 10'h025; zb = 10'h025;
    run_job(10'h020, 3, 10, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_rd != 12 || n_wr != 12 || n_done != 1) begin
      n_bad++;
      $display("FAIL multi_counts: to=%b rd=%0d wr=%0d done=%0d want 0/12/12/1", to, n_rd, n_wr, n_done);
    end
    n_cmp++;
    if (dw != 11 || gap != AS + 1) begin
      n_bad++;
      $display("FAIL multi_timing: dwell=%0d gap=%0d want 11/%0d", dw, gap, AS + 1);
    end
    zero_en = 1'b0;
    check_leftover("multi");
  endtask

  task automatic test_reset_mid;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    push_job(10'h040, 1);
    @(negedge clk);
    base_addr = 10'h040; num_tiles = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_rd_en, tile_valid, ibuf_wr_en, zero_cnt, mem_addr} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b done=%b rd=%b tv=%b wr=%b zc=%0d addr=%h want all 0",
               busy, done, mem_rd_en, tile_valid, ibuf_wr_en, zero_cnt, mem_addr);
    end
    n_cmp++;
    if (exp_addr.size() != 1) begin
      n_bad++;
      $display("FAIL pre_reset_reads: remaining=%0d want 1", exp_addr.size());
    end
    exp_addr.delete(); exp_wr.delete(); exp_zc.delete();
    @(negedge clk);
    nRST = 1'b1;
    run_job(10'h040, 1, 0, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_rd != 4 || n_done != 1 || t_valid != 6 || t_done != 7) begin
      n_bad++;
      $display("FAIL after_reset: to=%b rd=%0d done=%0d valid=%0d tdone=%0d want 0/4/1/6/7",
               to, n_rd, n_done, t_valid, t_done);
    end
    check_leftover("after_reset");
  endtask

  task automatic test_addr_wrap;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    run_job(10'h3FE, 1, 3, 1'b1, 2, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_rd != 4 || n_done != 1 || t_valid != 6 || dw != 4) begin
      n_bad++;
      $display("FAIL wrap_job: to=%b rd=%0d done=%0d valid=%0d dwell=%0d want 0/4/1/6/4",
               to, n_rd, n_done, t_valid, dw);
    end
    check_leftover("wrap");
  endtask

  task automatic test_back_to_back;
    int t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap;
    bit to;
    run_job(10'h3F0, 255, 0, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_rd != 1020 || n_wr != 1020 || n_done != 1 || gap != AS + 1) begin
      n_bad++;
      $display("FAIL max_tiles: to=%b rd=%0d wr=%0d done=%0d gap=%0d want 0/1020/1020/1/%0d",
               to, n_rd, n_wr, n_done, gap, AS + 1);
    end
    check_leftover("max_tiles");
    run_job(10'h200, 2, 0, 1'b0, -1, t_rd, t_valid, t_done, t_idle, n_rd, n_wr, n_done, dw, gap, to);
    n_cmp++;
    if (to || n_rd != 8 || n_done != 1 || t_rd != 1) begin
      n_bad++;
      $display("FAIL back_to_back: to=%b rd=%0d done=%0d first_rd=%0d want 0/8/1/1", to, n_rd, n_done, t_rd);
    end
    check_leftover("back_to_back");
  endtask

  initial begin
    nRST = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_tiles = '0;
    tile_ack = 1'b0;
    test_reset();
    test_single();
    test_zero_tiles();
    test_zero_words();
    test_multi_tile();
    test_reset_mid();
    test_addr_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
